led_pwm_fader: RTL and testbench

//   Breathing-colour PWM driver for the on-board RGB LED, sitting downstream of the PLL/counter

---
 rtl/led_pwm_fader.sv | 98 +++++++++
 tb/tb_led_pwm_fader.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/led_pwm_fader.sv
// Breathing-colour PWM driver for the RGB LED: one colour ramps 0->max->0,
// then the next colour takes over (RED->GREEN->BLUE->RED).
module led_pwm_fader #(
  parameter int PWM_WIDTH    = 8,
  parameter int STEP_PERIODS = 4
) (
  input  logic                 clock_12mhz,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 hold,
  output logic                 led_red,
  output logic                 led_green,
  output logic                 led_blue,
  output logic [1:0]           color,
  output logic [PWM_WIDTH-1:0] duty,
  output logic                 period_strobe
);

  localparam logic [PWM_WIDTH-1:0] MAX = '1;
  localparam int                   SW  = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [SW-1:0]        STEP_LAST = SW'(STEP_PERIODS - 1);

  typedef enum logic { RISE, FALL } ramp_t;
  typedef enum logic [1:0] { RED = 2'd0, GREEN = 2'd1, BLUE = 2'd2 } color_t;

  logic [PWM_WIDTH-1:0] r_pwm_cnt;
  logic [PWM_WIDTH-1:0] r_duty;
  logic [SW-1:0]        r_step_cnt;
  ramp_t                r_ramp;
  color_t               r_color;
  logic                 r_led_red;
  logic                 r_led_green;
  logic                 r_led_blue;
  logic                 r_strobe;
  logic                 w_cmp;

  assign w_cmp = (r_pwm_cnt < r_duty);

  always_ff @(posedge clock_12mhz) begin
    if (reset) begin
      r_pwm_cnt   <= '0;
      r_duty      <= '0;
      r_step_cnt  <= '0;
      r_ramp      <= RISE;
      r_color     <= RED;
      r_led_red   <= 1'b0;
      r_led_green <= 1'b0;
      r_led_blue  <= 1'b0;
      r_strobe    <= 1'b0;
    end else if (!enable) begin
      r_led_red   <= 1'b0;
      r_led_green <= 1'b0;
      r_led_blue  <= 1'b0;
      r_strobe    <= 1'b0;
    end else begin
      r_pwm_cnt   <= r_pwm_cnt + 1'b1;
      r_strobe    <= (r_pwm_cnt == MAX);
      r_led_red   <= (r_color == RED)   && w_cmp;
      r_led_green <= (r_color == GREEN) && w_cmp;
      r_led_blue  <= (r_color == BLUE)  && w_cmp;
      // Duty only moves on the wrap edge, so a new value starts at pwm_cnt==0.
      if (r_pwm_cnt == MAX && !hold) begin
        if (r_step_cnt == STEP_LAST) begin
          r_step_cnt <= '0;
          case (r_ramp)
            RISE: begin
              if (r_duty == MAX) r_ramp <= FALL;
              else               r_duty <= r_duty + 1'b1;
            end
            FALL: begin
              if (r_duty == '0) begin
                r_ramp <= RISE;
                case (r_color)
                  RED:     r_color <= GREEN;
                  GREEN:   r_color <= BLUE;
                  default: r_color <= RED;
                endcase
              end else begin
                r_duty <= r_duty - 1'b1;
              end
            end
            default: r_ramp <= RISE;
          endcase
        end else begin
          r_step_cnt <= r_step_cnt + 1'b1;
        end
      end
    end
  end

  assign led_red       = r_led_red;
  assign led_green     = r_led_green;
  assign led_blue      = r_led_blue;
  assign color         = r_color;
  assign duty          = r_duty;
  assign period_strobe = r_strobe;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Scoreboard bench for led_pwm_fader (PWM_WIDTH=4, STEP_PERIODS=1): one expected
// record per PWM period, checked by a monitor each time period_strobe fires.
module tb_led_pwm_fader;

  logic       clk = 1'b0;
  logic       reset, enable, hold;
  logic       led_red, led_green, led_blue, period_strobe;
  logic [1:0] color;
  logic [3:0] duty;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    int r, g, b, duty_after, color_after;
  } win_t;
  win_t exp_q[$];

  led_pwm_fader #(.PWM_WIDTH(4), .STEP_PERIODS(1)) dut (
    .clock_12mhz  (clk),
    .reset        (reset),
    .enable       (enable),
    .hold         (hold),
    .led_red      (led_red),
    .led_green    (led_green),
    .led_blue     (led_blue),
    .color        (color),
    .duty         (duty),
    .period_strobe(period_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Closed-form ramp: step s within a 32-step colour phase.
  function automatic int exp_duty(input int s);
    int q;
    q = s % 32;
    if (q <= 15) return q;
    if (q == 16) return 15;
    return 31 - q;
  endfunction

  function automatic int exp_color(input int s);
    return (s / 32) % 3;
  endfunction

  task automatic push(input int s_cur, input int s_after);
    win_t w;
    int   d, c;
    d = exp_duty(s_cur);
    c = exp_color(s_cur);
    w.r = (c == 0) ? d : 0;
    w.g = (c == 1) ? d : 0;
    w.b = (c == 2) ? d : 0;
    w.duty_after  = exp_duty(s_after);
    w.color_after = exp_color(s_after);
    exp_q.push_back(w);
  endtask

  task automatic wait_strobe();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (period_strobe) begin
        seen = 1'b1;
        break;
      end
    end
    chk("strobe_timeout", int'(seen), 1);
  endtask

  task automatic run_window(input int s_cur, input int s_after);
    push(s_cur, s_after);
    wait_strobe();
  endtask

  // Monitor: LED-high counts accumulate per window; the strobe cycle closes it.
  initial begin
    int cr, cg, cb;
    win_t w;
    cr = 0; cg = 0; cb = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        cr = 0; cg = 0; cb = 0;
      end else begin
        cr += int'(led_red);
        cg += int'(led_green);
        cb += int'(led_blue);
        if (period_strobe) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 1, 0);
          end else begin
            w = exp_q.pop_front();
            chk("red_count",   cr, w.r);
            chk("green_count", cg, w.g);
            chk("blue_count",  cb, w.b);
            chk("duty_next",   int'(duty),  w.duty_after);
            chk("color_next",  int'(color), w.color_after);
          end
          cr = 0; cg = 0; cb = 0;
        end
      end
    end
  end

  initial begin
    int first_strobe, anyled, anystb, s;
    reset = 1'b1; enable = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_leds",   int'({led_red, led_green, led_blue}), 0);
    chk("rst_color",  int'(color), 0);
    chk("rst_duty",   int'(duty), 0);
    chk("rst_strobe", int'(period_strobe), 0);
    reset = 1'b0; enable = 1'b1;

    push(0, 1);
    first_strobe = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (period_strobe) begin
        first_strobe = i;
        break;
      end
    end
    chk("first_strobe_cycle", first_strobe, 16);

    for (s = 1; s <= 102; s++) run_window(s, s + 1);

    hold = 1'b1;
    repeat (5) run_window(103, 103);
    hold = 1'b0;
    chk("hold_duty", int'(duty), 7);

    push(103, 104);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    anyled = 0; anystb = 0;
    repeat (20) begin
      @(negedge clk);
      anyled |= int'({led_red, led_green, led_blue});
      anystb |= int'(period_strobe);
    end
    chk("dis_leds",   anyled, 0);
    chk("dis_strobe", anystb, 0);
    chk("dis_duty",   int'(duty), 7);
    enable = 1'b1;
    wait_strobe();

    for (s = 104; s <= 149; s++) run_window(s, s + 1);
    chk("pre_rst_duty",  int'(duty), 9);
    chk("pre_rst_color", int'(color), 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_color",  int'(color), 0);
    chk("mid_rst_duty",   int'(duty), 0);
    chk("mid_rst_leds",   int'({led_red, led_green, led_blue}), 0);
    chk("mid_rst_strobe", int'(period_strobe), 0);
    reset = 1'b0;

    for (s = 0; s <= 19; s++) run_window(s, s + 1);
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
